// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte producers, the round-robin arbiter and the shared UART transmitter.
// The slave modport belongs to the arbiter; the master modport is the client/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int IDX_W   = 3
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_ready;
  logic                      busy;
  logic [IDX_W-1:0]          owner;
  logic                      done;

  modport master (
    output req, req_data, tx_ready,
    input  ack, tx_start, tx_data, busy, owner, done
  );

  modport slave (
    input  req, req_data, tx_ready,
    output ack, tx_start, tx_data, busy, owner, done
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ byte producers share one UART transmitter,
// granting one frame at a time and holding everyone else off until the stop bit is out.
//
// state       | meaning
// S_IDLE      | no frame in flight; grant the next requester once tx_ready is high
// S_LAUNCH    | tx_start and ack visible for this one cycle
// S_WAIT_BUSY | waiting for the transmitter to drop ready; times out after BUSY_TO cycles
// S_WAIT_DONE | frame on the wire; done pulses when ready rises again
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int IDX_W   = 3,
  parameter int BUSY_TO = 4
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int TO_W = $clog2(BUSY_TO + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [TO_W-1:0]     r_to_cnt;
  logic [NUM_REQ-1:0]  r_ack;
  logic                r_start;
  logic [DATA_W-1:0]   r_data;
  logic                r_busy;
  logic [IDX_W-1:0]    r_owner;
  logic                r_done;

  logic [IDX_W-1:0]    w_sel;
  logic                w_any;
  int                  w_dist;
  int                  w_best;
  logic [DATA_W-1:0]   w_sel_data;
  logic [IDX_W-1:0]    w_ptr_next;

  // Winner is the set request with the smallest forward distance from the pointer.
  always_comb begin
    w_sel  = '0;
    w_any  = 1'b0;
    w_dist = 0;
    w_best = NUM_REQ;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (bus.req[j]) begin
        w_dist = (j >= int'(r_ptr)) ? (j - int'(r_ptr)) : (j + NUM_REQ - int'(r_ptr));
        if (w_dist < w_best) begin
          w_best = w_dist;
          w_sel  = IDX_W'(j);
          w_any  = 1'b1;
        end
      end
    end
  end

  assign w_sel_data = bus.req_data[int'(w_sel)*DATA_W +: DATA_W];
  assign w_ptr_next = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_to_cnt <= '0;
      r_ack    <= '0;
      r_start  <= 1'b0;
      r_data   <= '0;
      r_busy   <= 1'b0;
      r_owner  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_ack   <= '0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any && bus.tx_ready) begin
            r_owner <= w_sel;
            r_data  <= w_sel_data;
            r_start <= 1'b1;
            r_ack   <= NUM_REQ'(1) << w_sel;
            r_busy  <= 1'b1;
            r_state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_ptr    <= w_ptr_next;
          r_to_cnt <= TO_W'(BUSY_TO - 1);
          r_state  <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          // A transmitter that never drops ready lost the start; release the bus anyway.
          if (!bus.tx_ready) begin
            r_state <= S_WAIT_DONE;
          end else if (r_to_cnt == '0) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt - TO_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (bus.tx_ready) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack      = r_ack;
  assign bus.tx_start = r_start;
  assign bus.tx_data  = r_data;
  assign bus.busy     = r_busy;
  assign bus.owner    = r_owner;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random requesters and a transmitter stub,
// with a transaction-level reference model compared against the outputs every cycle.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int IDX_W   = 3;
  localparam int BUSY_TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .IDX_W(IDX_W), .BUSY_TO(BUSY_TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter stub: after a start, ready falls after a delay and stays low for a frame length.
  bit cfg_rand = 0, cfg_lost = 0, cfg_glitch = 0, cfg_manual = 0, cfg_ready_val = 1;
  int cfg_delay = 0, cfg_len = 176;
  int stub_phase = 0, stub_cnt = 0, stub_len = 0, cur_delay = 0;

  always @(negedge clk) begin
    if (rst) begin
      stub_phase   = 0;
      bus.tx_ready = cfg_manual ? cfg_ready_val : 1'b1;
    end else if (cfg_manual) begin
      bus.tx_ready = cfg_ready_val;
    end else begin
      case (stub_phase)
        0: begin
          bus.tx_ready = !(cfg_glitch && $urandom_range(0, 15) == 0);
          if (bus.tx_start === 1'b1 && !cfg_lost) begin
            cur_delay = cfg_rand ? int'($urandom_range(0, 6)) : cfg_delay;
            stub_len  = cfg_rand ? int'($urandom_range(3, 30)) : cfg_len;
            if (cur_delay == 0) begin
              bus.tx_ready = 1'b0;
              stub_cnt     = stub_len;
              stub_phase   = 2;
            end else begin
              stub_cnt   = cur_delay;
              stub_phase = 1;
            end
          end
        end
        1: begin
          stub_cnt--;
          if (stub_cnt == 0) begin
            bus.tx_ready = 1'b0;
            stub_cnt     = stub_len;
            stub_phase   = 2;
          end
        end
        default: begin
          stub_cnt--;
          if (stub_cnt == 0) begin
            bus.tx_ready = 1'b1;
            stub_phase   = 0;
          end
        end
      endcase
    end
  end

  // Reference model: a frame is "in flight" from grant until ready has been seen low then high
  // again, or until ready stayed high for BUSY_TO cycles after the launch cycle.
  bit                 m_busy = 0, m_low = 0;
  int                 m_ptr = 0, m_age = 0, m_sel = 0;
  bit                 m_found;
  logic [NUM_REQ-1:0] e_ack = '0;
  bit                 e_start = 0, e_done = 0;
  logic [DATA_W-1:0]  e_data = '0;
  int                 e_owner = 0;

  always @(posedge clk) begin
    e_ack   = '0;
    e_start = 1'b0;
    e_done  = 1'b0;
    if (rst) begin
      m_busy  = 1'b0;
      m_ptr   = 0;
      e_data  = '0;
      e_owner = 0;
    end else if (!m_busy) begin
      if (bus.tx_ready && (bus.req != '0)) begin
        m_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
          if (!m_found && bus.req[(m_ptr + k) % NUM_REQ]) begin
            m_sel   = (m_ptr + k) % NUM_REQ;
            m_found = 1'b1;
          end
        end
        e_ack        = '0;
        e_ack[m_sel] = 1'b1;
        e_start      = 1'b1;
        e_data       = bus.req_data[m_sel*DATA_W +: DATA_W];
        e_owner      = m_sel;
        m_ptr        = (m_sel + 1) % NUM_REQ;
        m_busy       = 1'b1;
        m_age        = 0;
        m_low        = 1'b0;
      end
    end else begin
      m_age++;
      if (m_age >= 2) begin
        if (m_low) begin
          if (bus.tx_ready) begin
            e_done = 1'b1;
            m_busy = 1'b0;
          end
        end else if (!bus.tx_ready) begin
          m_low = 1'b1;
        end else if (m_age - 1 == BUSY_TO) begin
          e_done = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ack", bus.ack, e_ack);
      check("tx_start", bus.tx_start, e_start);
      check("tx_data", bus.tx_data, e_data);
      check("busy", bus.busy, m_busy);
      check("owner", bus.owner, e_owner);
      check("done", bus.done, e_done);
      check("ack_onehot", $countones(bus.ack) <= 1, 1);
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    bus.req = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
  endtask

  task automatic set_manual(input bit en, input bit v);
    @(posedge clk);
    #1 cfg_manual = en;
    cfg_ready_val = v;
    @(negedge clk);
  endtask

  task automatic wait_done(input string name, input int limit, output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.done, 1);
  endtask

  task automatic wait_ack(input string name, input int limit);
    int n = 0;
    while (bus.ack == '0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.ack != '0, 1);
  endtask

  function automatic void set_data(input int i, input logic [DATA_W-1:0] v);
    bus.req_data[i*DATA_W +: DATA_W] = v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n;
  int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    bus.req      = '0;
    bus.req_data = '0;

    // 1: single frame of A5 with a nominal-length transmitter.
    do_reset();
    check("rst_busy", bus.busy, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_owner", bus.owner, 0);
    set_data(0, 8'hA5);
    bus.req = 4'b0001;
    @(negedge clk);
    check("t1_start", bus.tx_start, 1);
    check("t1_data", bus.tx_data, 8'hA5);
    check("t1_ack", bus.ack, 4'b0001);
    bus.req = '0;
    wait_done("t1_done", 400, n);
    check("t1_done_window", (n >= 174 && n <= 178), 1);

    // 2: two simultaneous requests, pointer already past requester 0.
    cfg_len = 10;
    set_data(1, 8'h3C);
    set_data(2, 8'hC3);
    bus.req = 4'b0110;
    @(negedge clk);
    check("t2_first_owner", bus.owner, 1);
    check("t2_first_data", bus.tx_data, 8'h3C);
    check("t2_first_ack", bus.ack, 4'b0010);
    bus.req[1] = 1'b0;
    wait_done("t2_done1", 100, n);
    @(negedge clk);
    check("t2_ack_gap", n + 1, 12);
    check("t2_second_owner", bus.owner, 2);
    check("t2_second_data", bus.tx_data, 8'hC3);
    check("t2_second_ack", bus.ack, 4'b0100);
    bus.req[2] = 1'b0;
    wait_done("t2_done2", 100, n);

    // 3: all four requesting for eight frames from a fresh pointer.
    cfg_len = 6;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_data(i, DATA_W'(8'h10 + i));
    bus.req = 4'b1111;
    for (int f = 0; f < 8; f++) begin
      wait_ack("t3_ack_seen", 100);
      check("t3_owner", bus.owner, exp_order[f]);
      check("t3_ack", bus.ack, 32'd1 << exp_order[f]);
      if (f == 7) bus.req = '0;
      @(negedge clk);
      check("t3_ack_width", bus.ack, 0);
      wait_done("t3_done", 100, n);
    end

    // 4: reset in the middle of an owner-2 frame, then re-grant.
    cfg_len = 40;
    set_data(2, 8'hC3);
    bus.req = 4'b0100;
    wait_ack("t4_ack_seen", 20);
    check("t4_owner", bus.owner, 2);
    bus.req = '0;
    repeat (15) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t4_rst_busy", bus.busy, 0);
    check("t4_rst_start", bus.tx_start, 0);
    check("t4_rst_ack", bus.ack, 0);
    check("t4_rst_data", bus.tx_data, 0);
    check("t4_rst_owner", bus.owner, 0);
    check("t4_rst_done", bus.done, 0);
    set_data(2, 8'h5A);
    bus.req = 4'b0100;
    @(negedge clk);
    check("t4_regrant_ack", bus.ack, 4'b0100);
    check("t4_regrant_data", bus.tx_data, 8'h5A);
    bus.req = '0;
    wait_done("t4_done", 100, n);

    // 5: transmitter not ready holds off the grant.
    set_manual(1, 0);
    set_data(0, 8'h77);
    bus.req = 4'b0001;
    repeat (8) begin
      @(negedge clk);
      check("t5_no_start", bus.tx_start, 0);
    end
    set_manual(1, 1);
    @(negedge clk);
    check("t5_start", bus.tx_start, 1);
    check("t5_ack", bus.ack, 4'b0001);
    bus.req = '0;
    set_manual(1, 0);
    repeat (4) @(negedge clk);
    set_manual(0, 1);
    wait_done("t5_done", 20, n);

    // 6: lost start, ready never drops.
    cfg_lost = 1;
    set_data(0, 8'h42);
    bus.req = 4'b0001;
    @(negedge clk);
    check("t6_start", bus.tx_start, 1);
    bus.req = '0;
    wait_done("t6_done", 20, n);
    check("t6_timeout_latency", n, 5);
    cfg_lost = 0;
    set_data(1, 8'h99);
    bus.req = 4'b0010;
    wait_ack("t6_next_ack_seen", 20);
    check("t6_next_owner", bus.owner, 1);
    bus.req = '0;
    wait_done("t6_next_done", 100, n);

    // Random requesters, random transmitter timing, occasional resets.
    cfg_rand   = 1;
    cfg_glitch = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if ($urandom_range(0, 599) == 0) begin
        @(posedge clk);
        #1 rst = 1'b1;
        bus.req = '0;
        @(posedge clk);
        #1 rst = 1'b0;
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (bus.req[i]) begin
            if (bus.ack[i] || $urandom_range(0, 63) == 0) bus.req[i] = 1'b0;
          end else if ($urandom_range(0, 5) == 0) begin
            set_data(i, DATA_W'($urandom));
            bus.req[i] = 1'b1;
          end
        end
      end
    end
    bus.req = '0;
    repeat (60) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
